// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: opcodes, instruction field
// positions and default sizing.
package operand_fetch_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NREG_DEF   = 8;
  localparam int REG_AW     = 3;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_LDI = 4'd2;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file. R0 is hardwired to zero and a write in
// the same cycle as a read of that address is forwarded to the read port.
module reg_file_2r1w
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra_addr_i,
  input  logic [REG_AW-1:0] rb_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] regs_q [NREG];

  // NOTE: this array is reset on purpose because every entry must read zero
  // after reset; a plain storage array would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    ra_data_o = '0;
    rb_data_o = '0;
    if (ra_addr_i != '0) ra_data_o = (we_i && wa_i == ra_addr_i) ? wd_i : regs_q[ra_addr_i];
    if (rb_addr_i != '0) rb_data_o = (we_i && wa_i == rb_addr_i) ? wd_i : regs_q[rb_addr_i];
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: decodes an instruction, tracks in-flight destinations
// with a pending scoreboard and registers operands toward the adder stage.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_rd,
  output logic              out_we,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [7:0]        imm;
  logic [DATA_W-1:0] rs1_data, rs2_data;

  assign op  = in_instr[OP_MSB:OP_LSB];
  assign rd  = in_instr[RD_MSB:RD_LSB];
  assign rs1 = in_instr[RS1_MSB:RS1_LSB];
  assign rs2 = in_instr[RS2_MSB:RS2_LSB];
  assign imm = in_instr[IMM_MSB:IMM_LSB];

  reg_file_2r1w #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr_i (rs1),
    .rb_addr_i (rs2),
    .ra_data_o (rs1_data),
    .rb_data_o (rs2_data),
    .we_i      (wb_en),
    .wa_i      (wb_addr),
    .wd_i      (wb_data)
  );

  logic [DATA_W-1:0] dec_a, dec_b;
  logic              dec_we, uses_src;

  always_comb begin
    dec_a    = '0;
    dec_b    = '0;
    dec_we   = 1'b0;
    uses_src = 1'b0;
    case (op)
      OP_ADD: begin
        dec_a    = rs1_data;
        dec_b    = rs2_data;
        dec_we   = 1'b1;
        uses_src = 1'b1;
      end
      OP_LDI: begin
        dec_b  = DATA_W'(imm);
        dec_we = 1'b1;
      end
      default: ;
    endcase
  end

  logic [NREG-1:0] pending_q, pending_d;
  logic            rs1_busy, rs2_busy, hazard, accept;

  // A source is busy only if its writeback is not arriving this very cycle.
  assign rs1_busy = pending_q[rs1] && !(wb_en && wb_addr == rs1);
  assign rs2_busy = pending_q[rs2] && !(wb_en && wb_addr == rs2);
  assign hazard   = in_valid && uses_src && (rs1_busy || rs2_busy);
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Clear first, then set, so a same-cycle set takes precedence.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) pending_d[wb_addr] = 1'b0;
    if (accept && dec_we) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  logic              valid_q, we_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0]        rd_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (accept) begin
        valid_q <= 1'b1;
        a_q     <= dec_a;
        b_q     <= dec_b;
        rd_q    <= rd;
        we_q    <= dec_we;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_rd    = rd_q;
  assign out_we    = we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: inputs change and outputs are sampled on
// the falling edge, with in_ready checked 1 ns after inputs settle.
module tb_operand_fetch;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_we, wb_en;
  logic [15:0]   in_instr;
  logic [DW-1:0] out_a, out_b, wb_data;
  logic [2:0]    out_rd, wb_addr;

  int n_checks = 0;
  int n_fail   = 0;

  operand_fetch #(.DATA_W(DW), .NREG(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_rd    (out_rd),
    .out_we    (out_we),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [2:0] rd, input logic we);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".a"},     32'(out_a),     32'(a));
    check({tag, ".b"},     32'(out_b),     32'(b));
    check({tag, ".rd"},    32'(out_rd),    32'(rd));
    check({tag, ".we"},    32'(out_we),    32'(we));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic ordy);
    in_valid  = v;
    in_instr  = instr;
    out_ready = ordy;
  endtask

  task automatic wb(input logic en, input logic [2:0] addr, input logic [DW-1:0] data);
    wb_en   = en;
    wb_addr = addr;
    wb_data = data;
  endtask

  task automatic check_ready(input string tag, input logic exp);
    #1;
    check(tag, 32'(in_ready), 32'(exp));
  endtask

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'h2, rd, 1'b0, imm};
  endfunction

  function automatic logic [15:0] add(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    return {4'h1, rd, rs1, rs2, 3'b000};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    wb(1'b0, 3'd0, '0);
    step();
    check_out("reset", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    // Test 1: LDI accepted on the first edge after reset release
    rst_n = 1'b1;
    drive(1'b1, ldi(3'd1, 8'h05), 1'b1);
    check_ready("t1.ready", 1'b1);
    step();
    check_out("t1.ldi", 1'b1, 8'h00, 8'h05, 3'd1, 1'b1);

    // Test 2: RAW stall on R1 released by a same-cycle writeback
    drive(1'b1, add(3'd2, 3'd1, 3'd1), 1'b1);
    check_ready("t2.stall0", 1'b0);
    step();
    check("t2.drain", 32'(out_valid), 32'd0);
    check_ready("t2.stall1", 1'b0);
    wb(1'b1, 3'd1, 8'h05);
    check_ready("t2.release", 1'b1);
    step();
    wb(1'b0, 3'd0, '0);
    check_out("t2.add", 1'b1, 8'h05, 8'h05, 3'd2, 1'b1);

    // Test 3: backpressure holds the output register
    drive(1'b1, ldi(3'd3, 8'h22), 1'b0);
    check_ready("t3.bp_ready", 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("t3.hold", 1'b1, 8'h05, 8'h05, 3'd2, 1'b1);
      check_ready("t3.hold_ready", 1'b0);
    end
    out_ready = 1'b1;
    check_ready("t3.resume", 1'b1);
    step();
    check_out("t3.next", 1'b1, 8'h00, 8'h22, 3'd3, 1'b1);
    drive(1'b0, 16'h0000, 1'b1);
    step();
    check("t3.empty", 32'(out_valid), 32'd0);

    // Test 4: writes to R0 are dropped and R0 is never pending
    wb(1'b1, 3'd0, 8'hFF);
    step();
    drive(1'b1, add(3'd3, 3'd0, 3'd0), 1'b1);
    check_ready("t4.ready", 1'b1);
    step();
    wb(1'b0, 3'd0, '0);
    check_out("t4.add", 1'b1, 8'h00, 8'h00, 3'd3, 1'b1);

    // Test 5: set wins over a same-cycle clear of R4
    drive(1'b1, ldi(3'd4, 8'h11), 1'b1);
    step();
    check_out("t5.ldi1", 1'b1, 8'h00, 8'h11, 3'd4, 1'b1);
    drive(1'b1, ldi(3'd4, 8'h44), 1'b1);
    wb(1'b1, 3'd4, 8'h11);
    check_ready("t5.ldi2_ready", 1'b1);
    step();
    wb(1'b0, 3'd0, '0);
    check_out("t5.ldi2", 1'b1, 8'h00, 8'h44, 3'd4, 1'b1);
    drive(1'b1, add(3'd5, 3'd4, 3'd0), 1'b1);
    check_ready("t5.stall0", 1'b0);
    step();
    check("t5.drain", 32'(out_valid), 32'd0);
    wb(1'b1, 3'd6, 8'h66);
    check_ready("t5.other_wb", 1'b0);
    step();
    wb(1'b0, 3'd0, '0);
    check_ready("t5.stall2", 1'b0);
    wb(1'b1, 3'd4, 8'h44);
    check_ready("t5.release", 1'b1);
    step();
    wb(1'b0, 3'd0, '0);
    check_out("t5.add", 1'b1, 8'h44, 8'h00, 3'd5, 1'b1);

    // Writeback to a non-pending register still lands in the file
    drive(1'b1, add(3'd7, 3'd6, 3'd6), 1'b1);
    check_ready("wb_np.ready", 1'b1);
    step();
    check_out("wb_np.add", 1'b1, 8'h66, 8'h66, 3'd7, 1'b1);

    // Undefined opcode behaves as NOP
    drive(1'b1, 16'hF2C5, 1'b1);
    step();
    check_out("nop", 1'b1, 8'h00, 8'h00, 3'd1, 1'b0);

    // Test 6: reset mid-transfer
    drive(1'b1, add(3'd1, 3'd1, 3'd1), 1'b1);
    check_ready("t6.ready", 1'b1);
    step();
    check_out("t6.pre", 1'b1, 8'h05, 8'h05, 3'd1, 1'b1);
    drive(1'b0, 16'h0000, 1'b0);
    step();
    check("t6.held", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    wb(1'b1, 3'd1, 8'h77);
    #1;
    check_out("t6.in_reset", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    wb(1'b0, 3'd0, '0);
    drive(1'b1, add(3'd1, 3'd1, 3'd1), 1'b1);
    check_ready("t6.post_ready", 1'b1);
    step();
    check_out("t6.post_add", 1'b1, 8'h00, 8'h00, 3'd1, 1'b1);
    drive(1'b1, add(3'd2, 3'd7, 3'd5), 1'b1);
    check_ready("t6.pend_clear", 1'b1);
    step();
    check_out("t6.add2", 1'b1, 8'h00, 8'h00, 3'd2, 1'b1);

    drive(1'b0, 16'h0000, 1'b1);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
